// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value
);

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr) begin
      value <= '0;
    end else if (inc && (value != '1)) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch redirect
// and data-memory freeze, with saturating event counters and a sticky timeout.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       ifid_rs1_i,
  input  logic [4:0]       ifid_rs2_i,
  input  logic             ifid_use_rs1_i,
  input  logic             ifid_use_rs2_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rd_i,
  input  logic             branch_taken_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ready_i,
  output logic             pc_write_o,
  output logic             ifid_stall_o,
  output logic             ifid_flush_o,
  output logic             idex_stall_o,
  output logic             idex_flush_o,
  output logic             exmem_stall_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             timeout_o
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e            state, next_state;
  logic              freeze, load_use;
  logic [WAIT_W-1:0] wait_cnt;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    pc_write_o    = 1'b1;
    ifid_stall_o  = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_stall_o  = 1'b0;
    idex_flush_o  = 1'b0;
    exmem_stall_o = 1'b0;
    next_state    = RUN;

    freeze   = (state == RUN && dmem_req_i && !dmem_ready_i) ||
               (state == MEM_WAIT && !dmem_ready_i);
    load_use = idex_memread_i && (idex_rd_i != REG_X0) &&
               ((ifid_use_rs1_i && ifid_rs1_i == idex_rd_i) ||
                (ifid_use_rs2_i && ifid_rs2_i == idex_rd_i));

    // Branch is checked after load-use: its ID operands are stale during a load-use stall.
    if (rst_i) begin
      next_state = RUN;
    end else if (freeze) begin
      pc_write_o    = 1'b0;
      ifid_stall_o  = 1'b1;
      idex_stall_o  = 1'b1;
      exmem_stall_o = 1'b1;
      next_state    = MEM_WAIT;
    end else if (load_use) begin
      pc_write_o   = 1'b0;
      ifid_stall_o = 1'b1;
      idex_flush_o = 1'b1;
    end else if (branch_taken_i) begin
      ifid_flush_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= RUN;
      timeout_o <= 1'b0;
    end else begin
      state <= next_state;
      if (state == MEM_WAIT && wait_cnt == WAIT_LAST) begin
        timeout_o <= 1'b1;
      end
    end
  end

  sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (state == MEM_WAIT),
    .clr   (next_state == RUN),
    .value (wait_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (!pc_write_o),
    .clr   (1'b0),
    .value (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (ifid_flush_o),
    .clr   (1'b0),
    .value (flush_cnt_o)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: one default-parameter instance and one
// small instance (CNT_W=2, MEM_TIMEOUT=4) share the same stimulus.
module tb_pipe_hazard_ctrl;

  // Control vector order: {pc_write, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall}
  localparam logic [5:0] C_NORMAL = 6'b100000;
  localparam logic [5:0] C_LDUSE  = 6'b010010;
  localparam logic [5:0] C_BRANCH = 6'b101000;
  localparam logic [5:0] C_FREEZE = 6'b010101;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [4:0] ifid_rs1_i, ifid_rs2_i, idex_rd_i;
  logic       ifid_use_rs1_i, ifid_use_rs2_i, idex_memread_i;
  logic       branch_taken_i, dmem_req_i, dmem_ready_i;

  logic        a_pc, a_ifs, a_iff, a_ids, a_idf, a_exs, a_to;
  logic [15:0] a_stall, a_flush;
  logic        b_pc, b_ifs, b_iff, b_ids, b_idf, b_exs, b_to;
  logic [1:0]  b_stall, b_flush;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  pipe_hazard_ctrl dut_a (
    .clk_i(clk_i), .rst_i(rst_i),
    .ifid_rs1_i(ifid_rs1_i), .ifid_rs2_i(ifid_rs2_i),
    .ifid_use_rs1_i(ifid_use_rs1_i), .ifid_use_rs2_i(ifid_use_rs2_i),
    .idex_memread_i(idex_memread_i), .idex_rd_i(idex_rd_i),
    .branch_taken_i(branch_taken_i), .dmem_req_i(dmem_req_i), .dmem_ready_i(dmem_ready_i),
    .pc_write_o(a_pc), .ifid_stall_o(a_ifs), .ifid_flush_o(a_iff),
    .idex_stall_o(a_ids), .idex_flush_o(a_idf), .exmem_stall_o(a_exs),
    .stall_cnt_o(a_stall), .flush_cnt_o(a_flush), .timeout_o(a_to)
  );

  pipe_hazard_ctrl #(.CNT_W(2), .MEM_TIMEOUT(4)) dut_b (
    .clk_i(clk_i), .rst_i(rst_i),
    .ifid_rs1_i(ifid_rs1_i), .ifid_rs2_i(ifid_rs2_i),
    .ifid_use_rs1_i(ifid_use_rs1_i), .ifid_use_rs2_i(ifid_use_rs2_i),
    .idex_memread_i(idex_memread_i), .idex_rd_i(idex_rd_i),
    .branch_taken_i(branch_taken_i), .dmem_req_i(dmem_req_i), .dmem_ready_i(dmem_ready_i),
    .pc_write_o(b_pc), .ifid_stall_o(b_ifs), .ifid_flush_o(b_iff),
    .idex_stall_o(b_ids), .idex_flush_o(b_idf), .exmem_stall_o(b_exs),
    .stall_cnt_o(b_stall), .flush_cnt_o(b_flush), .timeout_o(b_to)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Control outputs are combinational: sample mid-cycle on the falling edge.
  task automatic check_ctrl(input string tag, input logic [5:0] exp);
    @(negedge clk_i);
    check({tag, "_a"}, {26'd0, a_pc, a_ifs, a_iff, a_ids, a_idf, a_exs}, {26'd0, exp});
    check({tag, "_b"}, {26'd0, b_pc, b_ifs, b_iff, b_ids, b_idf, b_exs}, {26'd0, exp});
  endtask

  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    ifid_rs1_i = 5'd0; ifid_rs2_i = 5'd0; idex_rd_i = 5'd0;
    ifid_use_rs1_i = 1'b0; ifid_use_rs2_i = 1'b0; idex_memread_i = 1'b0;
    branch_taken_i = 1'b0; dmem_req_i = 1'b0; dmem_ready_i = 1'b0;
  endtask

  task automatic load_use_rs1(input logic [4:0] r);
    idex_memread_i = 1'b1; idex_rd_i = r; ifid_rs1_i = r; ifid_use_rs1_i = 1'b1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    cycle();
    rst_i = 1'b0;
  endtask

  initial begin
    idle();
    rst_i = 1'b1;

    // Reset gating: a load-use pattern during reset must not stall.
    load_use_rs1(5'd5);
    check_ctrl("rst_ctrl", C_NORMAL);
    cycle();
    rst_i = 1'b0;
    idle();
    check("rst_stall_a", a_stall, 0);
    check("rst_flush_a", a_flush, 0);
    check("rst_to_b", b_to, 0);

    // Load-use on rs1
    load_use_rs1(5'd5);
    check_ctrl("lduse", C_LDUSE);
    cycle();
    idle();
    check_ctrl("lduse_after", C_NORMAL);
    check("lduse_stall_a", a_stall, 1);
    check("lduse_stall_b", b_stall, 1);

    // x0 never hazards; unused rs2 never hazards; used rs2 does
    idex_memread_i = 1'b1; idex_rd_i = 5'd0; ifid_rs1_i = 5'd0; ifid_use_rs1_i = 1'b1;
    check_ctrl("x0", C_NORMAL);
    cycle();
    idex_rd_i = 5'd7; ifid_rs1_i = 5'd3; ifid_rs2_i = 5'd7; ifid_use_rs2_i = 1'b0;
    check_ctrl("rs2_unused", C_NORMAL);
    cycle();
    ifid_use_rs2_i = 1'b1;
    check_ctrl("rs2_used", C_LDUSE);
    cycle();
    idle();
    check("rs2_stall_a", a_stall, 2);

    // Branch alone, then branch with load-use (load-use wins)
    do_reset();
    branch_taken_i = 1'b1;
    check_ctrl("branch", C_BRANCH);
    cycle();
    check("branch_flush_a", a_flush, 1);
    check("branch_stall_a", a_stall, 0);
    load_use_rs1(5'd9);
    check_ctrl("br_lduse", C_LDUSE);
    cycle();
    idle();
    check("br_lduse_flush_a", a_flush, 1);
    check("br_lduse_stall_a", a_stall, 1);

    // Memory wait: 3 frozen cycles, released on the 4th together with a load-use
    do_reset();
    dmem_req_i = 1'b1; dmem_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_ctrl($sformatf("memw_frz%0d", i), C_FREEZE);
      cycle();
    end
    check("memw_stall_a", a_stall, 3);
    dmem_ready_i = 1'b1;
    load_use_rs1(5'd4);
    check_ctrl("memw_release", C_LDUSE);
    cycle();
    idle();
    check_ctrl("memw_run", C_NORMAL);
    check("memw_stall4_a", a_stall, 4);
    check("memw_stall_sat_b", b_stall, 3);
    check("memw_to_b", b_to, 0);

    // Timeout with MEM_TIMEOUT=4: set after the 5th edge from the first freeze edge
    do_reset();
    dmem_req_i = 1'b1; dmem_ready_i = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      check_ctrl($sformatf("to_frz%0d", i), C_FREEZE);
      cycle();
      check($sformatf("to_edge%0d_b", i), b_to, (i == 5) ? 1 : 0);
    end
    check_ctrl("to_frz_after", C_FREEZE);
    dmem_ready_i = 1'b1;
    check_ctrl("to_release", C_NORMAL);
    cycle();
    idle();
    check("to_sticky_b", b_to, 1);
    check("to_none_a", a_to, 0);
    check("to_stall_a", a_stall, 5);

    // Reset in the middle of a wait abandons it and clears everything
    dmem_req_i = 1'b1;
    cycle();
    cycle();
    idle();
    rst_i = 1'b1;
    check_ctrl("rst_mid_ctrl", C_NORMAL);
    cycle();
    rst_i = 1'b0;
    check_ctrl("rst_mid_run", C_NORMAL);
    check("rst_mid_to_b", b_to, 0);
    check("rst_mid_stall_a", a_stall, 0);
    check("rst_mid_stall_b", b_stall, 0);

    // Saturation: 5 load-use cycles
    for (int i = 0; i < 5; i++) begin
      load_use_rs1(5'd12);
      cycle();
    end
    idle();
    check("sat_stall_b", b_stall, 3);
    check("sat_stall_a", a_stall, 5);
    check("sat_flush_b", b_flush, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline. Drives PC write enable and the stall/flush inputs of the IF/ID, ID/EX and EX/MEM pipeline registers.
- Detects load-use hazards and taken-branch redirects from ID, and freezes the whole pipeline while a data-memory access is outstanding.
- Keeps saturating stall and flush event counters, and a sticky memory-timeout flag.

Parameters:
- CNT_W, 16, width of the stall and flush event counters.
- MEM_TIMEOUT, 64, number of consecutive MEM_WAIT cycles after which timeout_o is set.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- ifid_rs1_i  in  5  rs1 field of the instruction in ID.
- ifid_rs2_i  in  5  rs2 field of the instruction in ID.
- ifid_use_rs1_i  in  1  ID instruction reads rs1.
- ifid_use_rs2_i  in  1  ID instruction reads rs2.
- idex_memread_i  in  1  instruction in EX is a load.
- idex_rd_i  in  5  destination register of the instruction in EX.
- branch_taken_i  in  1  branch/jump resolved taken in ID this cycle.
- dmem_req_i  in  1  MEM stage issues a data-memory access.
- dmem_ready_i  in  1  data memory completes the access this cycle.
- pc_write_o  out  1  PC update enable.
- ifid_stall_o  out  1  hold IF/ID.
- ifid_flush_o  out  1  clear IF/ID.
- idex_stall_o  out  1  hold ID/EX.
- idex_flush_o  out  1  insert bubble into ID/EX.
- exmem_stall_o  out  1  hold EX/MEM.
- stall_cnt_o  out  CNT_W  cycles with pc_write_o=0, saturating.
- flush_cnt_o  out  CNT_W  cycles with ifid_flush_o=1, saturating.
- timeout_o  out  1  sticky memory-timeout flag.

Behaviour:
- Reset: on a rising edge with rst_i=1:
  - state=RUN; stall_cnt_o=0, flush_cnt_o=0, timeout_o=0; wait counter=0.
  - Control outputs while rst_i=1: pc_write_o=1, all stall/flush outputs=0.
  - Reset mid-MEM_WAIT abandons the wait with no pending effect.
- Timing: control outputs are combinational (Mealy) on the current state and inputs, so they act in the same cycle. State, counters and timeout_o are registered.
- States: RUN, MEM_WAIT.
- Freeze condition: (state=RUN and dmem_req_i=1 and dmem_ready_i=0) or (state=MEM_WAIT and dmem_ready_i=0).
  - Outputs during freeze: pc_write_o=0; ifid_stall_o=1, idex_stall_o=1, exmem_stall_o=1; all flushes=0.
  - Next state is MEM_WAIT.
- MEM_WAIT with dmem_ready_i=1: release this cycle. Outputs are evaluated by the RUN rules below; next state is RUN.
- RUN with no freeze, evaluated in priority order:
  - 1. Load-use: idex_memread_i=1, idex_rd_i!=0, and (ifid_use_rs1_i and rs1==rd, or ifid_use_rs2_i and rs2==rd).
    - Outputs: pc_write_o=0, ifid_stall_o=1, idex_flush_o=1.
    - branch_taken_i is ignored this cycle, because its operands are stale.
  - 2. branch_taken_i=1: pc_write_o=1, ifid_flush_o=1.
  - 3. Otherwise: pc_write_o=1 and all stall/flush outputs=0.
- Invariants:
  - ifid_stall_o and ifid_flush_o are never both 1.
  - idex_stall_o and idex_flush_o are never both 1.
  - Register x0 (rd=0) never causes a hazard.
- Wait counter:
  - Increments each cycle the state is MEM_WAIT; clears on entry to RUN.
  - When it equals MEM_TIMEOUT-1 in MEM_WAIT, timeout_o is set at the next edge and stays set until reset.
  - The freeze continues after timeout.
- Event counters:
  - stall_cnt_o increments on each edge where pc_write_o=0; flush_cnt_o increments on each edge where ifid_flush_o=1.
  - Both saturate at 2^CNT_W-1. No wrap-around.

Decomposition:
- Package pipe_ctrl_pkg: state enum (RUN, MEM_WAIT) and constant REG_X0=5'd0.
- One sub-module, sat_counter (parameter W; ports inc, clr, value). Used for stall_cnt_o, flush_cnt_o and the wait counter; the wait counter uses clr.
- Hazard compare and priority mux stay inline.

Test Plan:
- Load-use:
  - Stimulus: idex_memread_i=1, idex_rd_i=5, ifid_rs1_i=5, ifid_use_rs1_i=1 for 1 cycle.
  - Required: that cycle pc_write_o=0, ifid_stall_o=1, idex_flush_o=1; next cycle (memread=0) all normal; stall_cnt_o=1.
- x0 and unused operand:
  - Stimulus: idex_rd_i=0 with rs1=0; then rd=7, rs2=7, ifid_use_rs2_i=0.
  - Required: no stall in either case; pc_write_o=1.
- Branch vs load-use:
  - Stimulus: branch_taken_i=1 alone, then branch_taken_i=1 together with a load-use match.
  - Required: first cycle ifid_flush_o=1, pc_write_o=1, flush_cnt_o=1. Second cycle ifid_flush_o=0, ifid_stall_o=1.
- Memory wait:
  - Stimulus: dmem_req_i=1 with dmem_ready_i=0 for 3 cycles, then ready=1.
  - Required: freeze outputs for 3 cycles, released in the 4th; stall_cnt_o=3; state returns to RUN.
- Timeout:
  - Stimulus: MEM_TIMEOUT=4, dmem_ready_i held at 0.
  - Required: timeout_o=1 after the 5th edge from the first freeze edge, and it stays 1 after ready. Applying rst_i=1 for 1 cycle clears timeout_o and all counters, and pc_write_o=1.
- Saturation:
  - Stimulus: CNT_W=2 with 5 load-use cycles.
  - Required: stall_cnt_o ends at 3.
